// File: rtl/alu_mc_pkg.sv
// Shared constants and types for the multi-cycle ALU: op-code encoding and FSM states.
package alu_pkg;

    localparam int OP_W = 4;

    // Op codes 0..4 keep the legacy 3-bit select encoding; 11..15 are illegal.
    typedef enum logic [OP_W-1:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_SLT  = 4'd8,
        OP_SLTU = 4'd9,
        OP_MUL  = 4'd10
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/alu_mc_if.sv
// Operand/result handshake bundle between decode, the ALU and the writeback register.
interface alu_mc_if #(parameter int WIDTH = 32);

    logic                     in_valid;
    logic                     in_ready;
    logic [alu_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]         a;
    logic [WIDTH-1:0]         b;
    logic                     out_valid;
    logic                     out_ready;
    logic [WIDTH-1:0]         result;
    logic                     zero;
    logic                     err;
    logic                     busy;

    // The ALU side.
    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, zero, err, busy
    );

    // The decode/writeback side that drives operands and consumes results.
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, zero, err, busy
    );

endinterface

// File: rtl/alu_mc_mul_iter.sv
// Shift-add multiplier: one partial product per cycle, WIDTH cycles from start to done.
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] product_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0]    count_q;
    logic             running_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] accNext;

    // Partial-product add for the current multiplier bit; on the last step this is the product.
    always_comb begin
        accNext = acc_q + (mplier_q[0] ? mcand_q : '0);
    end

    // Load operands on start, then shift multiplicand left and multiplier right each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
        end else if (start_i) begin
            count_q   <= '0;
            running_q <= 1'b1;
            acc_q     <= '0;
            mcand_q   <= a_i;
            mplier_q  <= b_i;
        end else if (running_q) begin
            acc_q    <= accNext;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            count_q  <= count_q + 1'b1;
            if (count_q == LAST) begin
                running_q <= 1'b0;
            end
        end
    end

    assign done_o    = running_q && (count_q == LAST);
    assign product_o = accNext;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU with valid/ready handshakes and a registered result.
// Optional feature macro ALU_MUL_EN: builds the iterative multiplier for OP_MUL;
// without it OP_MUL is reported as illegal and busy is tied low.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_mc_if.slave  bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             err_q;
    logic             outValid_q;
    logic             inReady;
    logic             busyFlag;
    logic             accept;
    logic             acceptAlu;
    logic [WIDTH-1:0] aluRes;
    logic             legal;
    logic [SHW-1:0]   shamt;

    // Single-cycle operations and legality decode from the presented operands.
    always_comb begin
        aluRes = '0;
        legal  = 1'b1;
        shamt  = bus.b[SHW-1:0];
        case (bus.op)
            OP_ADD:  aluRes = bus.a + bus.b;
            OP_SUB:  aluRes = bus.a - bus.b;
            OP_AND:  aluRes = bus.a & bus.b;
            OP_OR:   aluRes = bus.a | bus.b;
            OP_XOR:  aluRes = bus.a ^ bus.b;
            OP_SLL:  aluRes = bus.a << shamt;
            OP_SRL:  aluRes = bus.a >> shamt;
            OP_SRA:  aluRes = $signed(bus.a) >>> shamt;
            OP_SLT:  aluRes = WIDTH'($signed(bus.a) < $signed(bus.b));
            OP_SLTU: aluRes = WIDTH'(bus.a < bus.b);
`ifdef ALU_MUL_EN
            OP_MUL:  aluRes = '0;
`endif
            default: legal  = 1'b0;
        endcase
    end

    assign accept = bus.in_valid && inReady;

`ifdef ALU_MUL_EN
    state_e           state_q;
    state_e           state_d;
    logic             isMul;
    logic             mulDone;
    logic [WIDTH-1:0] mulProduct;

    assign isMul     = (bus.op == OP_MUL);
    assign acceptAlu = accept && !isMul;

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_i   (accept && isMul),
        .a_i       (bus.a),
        .b_i       (bus.b),
        .done_o    (mulDone),
        .product_o (mulProduct)
    );

    // State register; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Enter MUL_BUSY on an accepted multiply, leave on the final iteration.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (accept && isMul) state_d = ST_MUL_BUSY;
            ST_MUL_BUSY: if (mulDone)         state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs depend only on state, the output register and out_ready.
    always_comb begin
        inReady  = rst_n && (state_q == ST_IDLE) && (!outValid_q || bus.out_ready);
        busyFlag = (state_q == ST_MUL_BUSY);
    end
`else
    assign acceptAlu = accept;

    // Without the multiplier the block is always idle; only the output register stalls it.
    always_comb begin
        inReady  = rst_n && (!outValid_q || bus.out_ready);
        busyFlag = 1'b0;
    end
`endif

    // Output register: load on a single-cycle accept or multiply completion, hold under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q   <= '0;
            zero_q     <= 1'b0;
            err_q      <= 1'b0;
            outValid_q <= 1'b0;
        end else if (acceptAlu) begin
            result_q   <= legal ? aluRes : '0;
            zero_q     <= legal ? (aluRes == '0) : 1'b1;
            err_q      <= !legal;
            outValid_q <= 1'b1;
`ifdef ALU_MUL_EN
        end else if (mulDone) begin
            result_q   <= mulProduct;
            zero_q     <= (mulProduct == '0);
            err_q      <= 1'b0;
            outValid_q <= 1'b1;
`endif
        end else if (outValid_q && bus.out_ready) begin
            outValid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.busy      = busyFlag;
    assign bus.out_valid = outValid_q;
    assign bus.result    = result_q;
    assign bus.zero      = zero_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed testbench for alu_mc at WIDTH=32; expectations follow ALU_MUL_EN when it is defined.
module tb_alu_mc;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_mc_if #(.WIDTH(32)) bus ();

    alu_mc #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present one operation for a single cycle, return 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Check the full result triple after an accepting edge.
    task automatic checkResult(input string tag, input logic [31:0] res, input logic z, input logic e);
        checkOutput({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        checkOutput({tag, "_result"}, bus.result, res);
        checkOutput({tag, "_zero"}, 32'(bus.zero), 32'(z));
        checkOutput({tag, "_err"}, 32'(bus.err), 32'(e));
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.op       = 4'd0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ready = 1'b1;

        // Reset values
        #2;
        checkOutput("rst_outvalid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_result", bus.result, 32'd0);
        checkOutput("rst_zero", 32'(bus.zero), 32'd0);
        checkOutput("rst_err", 32'(bus.err), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_inready", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("post_rst_inready", 32'(bus.in_ready), 32'd1);

        // Basic arithmetic, logic, shifts and compares
        applyStimulus(4'd0, 32'd15, 32'd5);
        checkResult("add", 32'd20, 1'b0, 1'b0);
        applyStimulus(4'd1, 32'd15, 32'd15);
        checkResult("sub_zero", 32'd0, 1'b1, 1'b0);
        applyStimulus(4'd1, 32'd0, 32'd1);
        checkResult("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);
        applyStimulus(4'd2, 32'hF0F0_1234, 32'h0FF0_FF00);
        checkOutput("and", bus.result, 32'h00F0_1200);
        applyStimulus(4'd3, 32'hF000_0001, 32'h0000_0F00);
        checkOutput("or", bus.result, 32'hF000_0F01);
        applyStimulus(4'd5, 32'h0000_0003, 32'h0000_0024);
        checkOutput("sll_shamt_low_bits", bus.result, 32'h0000_0030);
        applyStimulus(4'd7, 32'h8000_0000, 32'd4);
        checkOutput("sra", bus.result, 32'hF800_0000);
        applyStimulus(4'd6, 32'h8000_0000, 32'd4);
        checkOutput("srl", bus.result, 32'h0800_0000);
        applyStimulus(4'd8, 32'hFFFF_FFFF, 32'd1);
        checkResult("slt", 32'd1, 1'b0, 1'b0);
        applyStimulus(4'd9, 32'hFFFF_FFFF, 32'd1);
        checkResult("sltu", 32'd0, 1'b1, 1'b0);

        // Multiply
        applyStimulus(4'd10, 32'd1234, 32'd5678);
`ifdef ALU_MUL_EN
        checkOutput("mul_accept_state", {29'd0, bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
        for (int i = 1; i < 32; i++) begin
            @(posedge clk);
            #1;
            checkOutput("mul_busy_state", {29'd0, bus.busy, bus.in_ready, bus.out_valid}, 32'b100);
        end
        @(posedge clk);
        #1;
        checkResult("mul", 32'd7006652, 1'b0, 1'b0);
        checkOutput("mul_done_busy", 32'(bus.busy), 32'd0);
`else
        checkResult("mul_disabled", 32'd0, 1'b1, 1'b1);
        checkOutput("mul_disabled_busy", 32'(bus.busy), 32'd0);
`endif

        // Back-to-back throughput with out_ready high
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op       = 4'd0;
        bus.a        = 32'd10;
        bus.b        = 32'd20;
        @(posedge clk);
        #1;
        checkOutput("thru_first", bus.result, 32'd30);
        bus.op = 4'd1;
        bus.a  = 32'd50;
        bus.b  = 32'd8;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        checkResult("thru_second", 32'd42, 1'b0, 1'b0);

        // Backpressure: let the output drain, then hold the XOR result
        @(posedge clk);
        #1;
        checkOutput("drained", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        applyStimulus(4'd4, 32'hFFFF_FFFF, 32'h0000_FFFF);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            checkResult("bp_hold", 32'hFFFF_0000, 1'b0, 1'b0);
            checkOutput("bp_inready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_release_inready", 32'(bus.in_ready), 32'd1);
        applyStimulus(4'd0, 32'd3, 32'd4);
        checkResult("bp_next", 32'd7, 1'b0, 1'b0);

        // Illegal op, then a legal op clears err
        applyStimulus(4'hF, 32'h1234_5678, 32'h9ABC_DEF0);
        checkResult("illegal", 32'd0, 1'b1, 1'b1);
        applyStimulus(4'd0, 32'd2, 32'd3);
        checkResult("after_illegal", 32'd5, 1'b0, 1'b0);

        // Reset during multiply cycle 10
        applyStimulus(4'd10, 32'd1234, 32'd5678);
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_outvalid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_result", bus.result, 32'd0);
        checkOutput("midrst_zero", 32'(bus.zero), 32'd0);
        checkOutput("midrst_err", 32'(bus.err), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_inready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("midrst_release_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_release_inready", 32'(bus.in_ready), 32'd1);
        applyStimulus(4'd0, 32'd1, 32'd1);
        checkResult("post_midrst_add", 32'd2, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("final_drain", 32'(bus.out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the RISC-V execute stage, successor to the combinational 3-bit-select ALU. Adds WIDTH generalisation, shifts, signed/unsigned compares, an optional iterative multiplier, a zero flag and valid/ready handshakes on input and output. It sits between the decode/operand-fetch stage and the writeback register, and back-pressures decode while a multiply is in flight.

## Interface
- WIDTH, 32, operand/result width; power of two, minimum 8
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and op presented
- in_ready  out  1  block accepts an operation this cycle
- op  in  4  operation code, see Operation
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; shifts use b[$clog2(WIDTH)-1:0]
- out_valid  out  1  result registered and held
- out_ready  in  1  consumer takes the result this cycle
- result  out  WIDTH  registered result
- zero  out  1  result == 0
- err  out  1  op was illegal or not compiled in
- busy  out  1  multiply in progress

## Operation
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR (legacy sel encoding kept), 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low WIDTH bits of a*b); 11–15 illegal.
- ADD/SUB wrap modulo 2^WIDTH; no carry/overflow output.
- Accept = in_valid && in_ready. in_ready = rst_n && state==IDLE && (!out_valid || out_ready).
- FSM: IDLE, MUL_BUSY.
  - IDLE, accept of non-MUL op: result, zero, err loaded at that edge; out_valid set; stay IDLE.
  - IDLE, accept of MUL: latch operands, counter=0, go MUL_BUSY; busy=1.
  - MUL_BUSY: one shift-add iteration per cycle; on iteration WIDTH-1 load result/zero, err=0, set out_valid, return IDLE.
- Output register holds result/zero/err while out_valid && !out_ready. out_valid clears on out_ready unless a new op is accepted the same cycle (then it stays 1 with new data).
- Illegal op: result 0, zero 1, err 1, single-cycle path.
- in_valid while in_ready low is ignored (not queued); the source must hold.
- Reset: out_valid 0, result 0, zero 0, err 0, busy 0, in_ready 0, state IDLE. Reset mid-multiply aborts it, with no output produced.

## Timing
- Non-MUL latency: 1 cycle (accept at edge k, out_valid high after edge k).
- MUL latency: WIDTH cycles (out_valid high after edge k+WIDTH); in_ready low for those cycles.
- Throughput: one non-MUL op per cycle with out_ready held high.
- No combinational path from in_valid/a/b/op to any output; in_ready depends combinationally only on out_ready and state.

## Configuration
- ALU_MUL_EN defined: op 10 uses the iterative multiplier as above.
- Not defined: op 10 is treated as illegal (1 cycle, result 0, err 1); MUL_BUSY and the multiplier are not built; busy tied 0.

## Structure
- alu_pkg: OP_W=4 constant, op-code localparams/enum (OP_ADD … OP_MUL), state enum.
- One sub-module alu_mul_iter: shift-add multiplier with start/done, WIDTH parameter, instantiated only under ALU_MUL_EN.

## Test plan (WIDTH=32)
- ADD a=15, b=5 -> result 20, zero 0, err 0, out_valid one cycle after accept; SUB 15,15 -> result 0, zero 1.
- SRA a=0x80000000, b=4 -> 0xF8000000; SRL same -> 0x08000000; SLT a=0xFFFFFFFF, b=1 -> 1; SLTU same -> 0.
- MUL a=1234, b=5678 -> 7006652 exactly 32 cycles after accept; busy 1 and in_ready 0 throughout; without ALU_MUL_EN -> result 0, err 1 after 1 cycle.
- Backpressure: XOR 0xFFFFFFFF^0x0000FFFF -> 0xFFFF0000 held 3 cycles with out_ready 0; in_ready 0; second op accepted the cycle out_ready rises, new result next cycle.
- Illegal op 4'hF -> result 0, zero 1, err 1; next legal op clears err.
- Assert rst_n low during MUL cycle 10 -> all outputs at reset values; after release, ADD 1+1 -> 2.
